// File: rtl/irq_dispatch_pkg.sv
// Shared types and constants for the interrupt dispatch stage.
// Optional timeout behaviour is selected in irq_dispatch by IRQ_DISPATCH_TIMEOUT_EN.
package irq_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        REQ     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    localparam logic [1:0] GRP_A = 2'd0;
    localparam logic [1:0] GRP_B = 2'd1;
    localparam logic [1:0] GRP_C = 2'd2;

    localparam int NUM_CHAN = 9;
    localparam int VEC_W    = 5;

    // Linear vector: grp * NUM_CHAN + chan; at most 2*9+8 = 26 for valid channels.
    function automatic logic [VEC_W-1:0] grp_chan_to_vec(input logic [1:0] grp,
                                                         input logic [3:0] chan);
        return ({3'd0, grp} * 5'(NUM_CHAN)) + {1'b0, chan};
    endfunction

endpackage

// File: rtl/irq_vec_encode.sv
// Combinational group select and vector encode of the priority controller outputs.
// Shared by the qualify compare and the vector latch in irq_dispatch.
module irq_vec_encode
    import irq_dispatch_pkg::*;
(
    input  logic             pa,
    input  logic             pb,
    input  logic             pc,
    input  logic [3:0]       chan,
    output logic             valid,
    output logic [1:0]       grp,
    output logic [VEC_W-1:0] vec,
    output logic             chan_ok
);

    // Fixed-priority group select with vector arithmetic.
    always_comb begin
        valid   = pa | pb | pc;
        grp     = GRP_A;
        if (pa) begin
            grp = GRP_A;
        end else if (pb) begin
            grp = GRP_B;
        end else if (pc) begin
            grp = GRP_C;
        end else begin
            grp = GRP_A;
        end
        chan_ok = (chan < 4'(NUM_CHAN));
        vec     = grp_chan_to_vec(grp, chan);
    end

endmodule

// File: rtl/irq_dispatch.sv
// Two-sample qualification and req/ack/eoi dispatch of the winning interrupt.
// Define IRQ_DISPATCH_TIMEOUT_EN to abandon unacknowledged requests and expose timeout_err.
module irq_dispatch
    import irq_dispatch_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pa,
    input  logic             pb,
    input  logic             pc,
    input  logic [3:0]       chan,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic             busy,
    output logic             bad_chan,
    output logic [CNT_W-1:0] dispatch_cnt
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    state_t             state_r;
    state_t             state_s;
    logic [1:0]         cap_grp_r;
    logic [3:0]         cap_chan_r;
    logic               enc_valid_s;
    logic [1:0]         enc_grp_s;
    logic [VEC_W-1:0]   enc_vec_s;
    logic               enc_chan_ok_s;
    logic               same_s;
    logic               capture_s;
    logic               latch_s;
    logic               bad_s;
    logic               accept_s;
    logic               tmr_expire_s;

    irq_vec_encode u_enc (
        .pa      (pa),
        .pb      (pb),
        .pc      (pc),
        .chan    (chan),
        .valid   (enc_valid_s),
        .grp     (enc_grp_s),
        .vec     (enc_vec_s),
        .chan_ok (enc_chan_ok_s)
    );

    assign same_s = (enc_grp_s == cap_grp_r) && (chan == cap_chan_r);

`ifdef IRQ_DISPATCH_TIMEOUT_EN
    localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
    logic [TMR_W-1:0] tmr_r;

    assign tmr_expire_s = (tmr_r == TMR_W'(ACK_TIMEOUT - 1));

    // REQ dwell counter and sticky timeout flag; an ack in the expiry cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_r       <= {TMR_W{1'b0}};
            timeout_err <= 1'b0;
        end else begin
            if (latch_s) begin
                tmr_r <= {TMR_W{1'b0}};
            end else if (state_r == REQ) begin
                tmr_r <= tmr_r + TMR_W'(1);
            end else begin
                tmr_r <= tmr_r;
            end
            if ((state_r == REQ) && (state_s == IDLE)) begin
                timeout_err <= 1'b1;
            end else begin
                timeout_err <= timeout_err;
            end
        end
    end
`else
    assign tmr_expire_s = 1'b0;
`endif

    // Next-state and per-cycle action decode.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        latch_s   = 1'b0;
        bad_s     = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (enc_valid_s) begin
                    state_s   = QUAL;
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            QUAL: begin
                if (!enc_valid_s) begin
                    state_s = IDLE;
                end else if (same_s) begin
                    if (enc_chan_ok_s) begin
                        state_s = REQ;
                        latch_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                        bad_s   = 1'b1;
                    end
                end else begin
                    state_s   = QUAL;
                    capture_s = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_s  = SERVICE;
                    accept_s = 1'b1;
                end else if (tmr_expire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_s = IDLE;
                end else begin
                    state_s = SERVICE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, capture registers and registered outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cap_grp_r    <= 2'd0;
            cap_chan_r   <= 4'd0;
            int_req      <= 1'b0;
            int_vec      <= {VEC_W{1'b0}};
            busy         <= 1'b0;
            bad_chan     <= 1'b0;
            dispatch_cnt <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            int_req  <= (state_s == REQ);
            busy     <= (state_s != IDLE);
            bad_chan <= bad_s;
            if (capture_s) begin
                cap_grp_r  <= enc_grp_s;
                cap_chan_r <= chan;
            end else begin
                cap_grp_r  <= cap_grp_r;
                cap_chan_r <= cap_chan_r;
            end
            if (latch_s) begin
                int_vec <= enc_vec_s;
            end else if (state_s == IDLE) begin
                int_vec <= {VEC_W{1'b0}};
            end else begin
                int_vec <= int_vec;
            end
            if (accept_s) begin
                dispatch_cnt <= dispatch_cnt + CNT_W'(1);
            end else begin
                dispatch_cnt <= dispatch_cnt;
            end
        end
    end

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: cycle model plus directed literal checks.
// Timeout scenarios are exercised when IRQ_DISPATCH_TIMEOUT_EN is defined.
module tb_irq_dispatch;

    localparam int CNT_W       = 8;
    localparam int ACK_TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic             pa;
    logic             pb;
    logic             pc;
    logic [3:0]       chan;
    logic             int_ack;
    logic             eoi;
    logic             int_req;
    logic [4:0]       int_vec;
    logic             busy;
    logic             bad_chan;
    logic [CNT_W-1:0] dispatch_cnt;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    logic             timeout_err;
`endif

    int tests;
    int fails;

    irq_dispatch #(.CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pa           (pa),
        .pb           (pb),
        .pc           (pc),
        .chan         (chan),
        .int_ack      (int_ack),
        .eoi          (eoi),
        .int_req      (int_req),
        .int_vec      (int_vec),
        .busy         (busy),
        .bad_chan     (bad_chan),
        .dispatch_cnt (dispatch_cnt)
`ifdef IRQ_DISPATCH_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: phase 0 idle, 1 qualifying, 2 requesting, 3 in service.
    int m_phase, m_cap, m_vec, m_cnt, m_tmr;
    bit m_req, m_busy, m_bad, m_terr;
    int g_now, key_now, vec_now;
    bit act_now;

    always_comb begin
        act_now = pa | pb | pc;
        g_now   = pa ? 0 : (pb ? 1 : 2);
        key_now = g_now * 16 + int'(chan);
        vec_now = g_now * 9 + int'(chan);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_cap <= 0; m_vec <= 0; m_cnt <= 0; m_tmr <= 0;
            m_req <= 1'b0; m_busy <= 1'b0; m_bad <= 1'b0; m_terr <= 1'b0;
        end else begin
            m_bad <= 1'b0;
            case (m_phase)
                0: if (act_now) begin
                    m_cap <= key_now; m_phase <= 1; m_busy <= 1'b1;
                end
                1: if (!act_now) begin
                    m_phase <= 0; m_busy <= 1'b0;
                end else if (key_now == m_cap) begin
                    if (chan < 4'd9) begin
                        m_phase <= 2; m_req <= 1'b1; m_vec <= vec_now; m_tmr <= 0;
                    end else begin
                        m_bad <= 1'b1; m_phase <= 0; m_busy <= 1'b0;
                    end
                end else begin
                    m_cap <= key_now;
                end
                2: if (int_ack) begin
                    m_phase <= 3; m_req <= 1'b0; m_cnt <= (m_cnt + 1) % 256;
                end
`ifdef IRQ_DISPATCH_TIMEOUT_EN
                else if (m_tmr + 1 >= ACK_TIMEOUT) begin
                    m_phase <= 0; m_req <= 1'b0; m_busy <= 1'b0; m_terr <= 1'b1;
                end else begin
                    m_tmr <= m_tmr + 1;
                end
`endif
                3: if (eoi) begin
                    m_phase <= 0; m_busy <= 1'b0;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("int_req", int'(int_req), int'(m_req));
            check("busy", int'(busy), int'(m_busy));
            check("bad_chan", int'(bad_chan), int'(m_bad));
            check("dispatch_cnt", int'(dispatch_cnt), m_cnt);
            if (m_phase >= 2) check("int_vec", int'(int_vec), m_vec);
`ifdef IRQ_DISPATCH_TIMEOUT_EN
            check("timeout_err", int'(timeout_err), int'(m_terr));
`endif
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drive(input logic a, input logic b, input logic c, input logic [3:0] ch);
        pa = a; pb = b; pc = c; chan = ch;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_int_req"}, int'(int_req), 0);
        check({tag, "_int_vec"}, int'(int_vec), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_bad_chan"}, int'(bad_chan), 0);
        check({tag, "_cnt"}, int'(dispatch_cnt), 0);
`ifdef IRQ_DISPATCH_TIMEOUT_EN
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
`endif
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; int_ack = 1'b0; eoi = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // pb, chan 4: two-cycle latency, vector 13, ack then eoi
        drive(1'b0, 1'b1, 1'b0, 4'd4);
        tick(1);
        check("s1_busy_qual", int'(busy), 1);
        check("s1_req_qual", int'(int_req), 0);
        tick(1);
        check("s1_req", int'(int_req), 1);
        check("s1_vec", int'(int_vec), 13);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("s1_req_drop", int'(int_req), 0);
        check("s1_cnt", int'(dispatch_cnt), 1);
        check("s1_busy_svc", int'(busy), 1);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        check("s1_busy_idle", int'(busy), 0);

        // pa wins over pb/pc; simultaneous ack+eoi in REQ keeps SERVICE
        drive(1'b1, 1'b1, 1'b1, 4'd2);
        tick(2);
        check("s2_vec", int'(int_vec), 2);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        int_ack = 1'b1; eoi = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("s2_cnt", int'(dispatch_cnt), 2);
        check("s2_busy_eoi_dropped", int'(busy), 1);
        tick(1);
        eoi = 1'b0;
        check("s2_idle", int'(busy), 0);

        // channel changes during qualification
        drive(1'b0, 1'b0, 1'b1, 4'd1);
        tick(1);
        drive(1'b0, 1'b0, 1'b1, 4'd3);
        tick(1);
        check("s3_no_req", int'(int_req), 0);
        check("s3_busy", int'(busy), 1);
        tick(1);
        check("s3_req", int'(int_req), 1);
        check("s3_vec", int'(int_vec), 21);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        eoi = 1'b1; tick(1); eoi = 1'b0;

        // out-of-range channel
        drive(1'b1, 1'b0, 1'b0, 4'd11);
        tick(2);
        check("s4_bad", int'(bad_chan), 1);
        check("s4_req", int'(int_req), 0);
        check("s4_busy", int'(busy), 0);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        tick(1);
        check("s4_bad_pulse", int'(bad_chan), 0);

        // stray ack/eoi while idle are ignored
        int_ack = 1'b1; eoi = 1'b1;
        tick(2);
        int_ack = 1'b0; eoi = 1'b0;
        check("stray_cnt", int'(dispatch_cnt), 3);
        check("stray_busy", int'(busy), 0);

        // back-to-back minimum-period dispatches up to counter wrap
        for (int i = 0; i < 253; i++) begin
            drive((i % 3) == 0, (i % 3) == 1, (i % 3) == 2, 4'(i % 9));
            tick(2);
            drive(1'b0, 1'b0, 1'b0, 4'd0);
            int_ack = 1'b1; tick(1); int_ack = 1'b0;
            eoi = 1'b1; tick(1); eoi = 1'b0;
        end
        check("wrap_cnt", int'(dispatch_cnt), 0);

`ifdef IRQ_DISPATCH_TIMEOUT_EN
        // no ack: request abandoned after 16 REQ cycles
        drive(1'b1, 1'b0, 1'b0, 4'd5);
        tick(2);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        check("to_req", int'(int_req), 1);
        tick(15);
        check("to_req_held", int'(int_req), 1);
        tick(1);
        check("to_req_drop", int'(int_req), 0);
        check("to_err", int'(timeout_err), 1);
        check("to_cnt", int'(dispatch_cnt), 0);
        check("to_busy", int'(busy), 0);

        // ack in the expiry cycle wins
        drive(1'b0, 1'b1, 1'b0, 4'd7);
        tick(2);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        tick(15);
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        check("to_ack_wins_busy", int'(busy), 1);
        check("to_ack_wins_cnt", int'(dispatch_cnt), 1);
        check("to_err_sticky", int'(timeout_err), 1);
        eoi = 1'b1; tick(1); eoi = 1'b0;
`endif

        // asynchronous reset while in SERVICE
        drive(1'b0, 1'b0, 1'b1, 4'd8);
        tick(2);
        check("rs_vec", int'(int_vec), 26);
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        check("rs_busy_svc", int'(busy), 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick(1);
        rst = 1'b0;
        tick(2);
        check("post_rst_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
